// File: rtl/matrix_scroll_disp.sv
// Scrolling column-scan LED matrix driver: COLS-wide window onto a BUF_COLS frame buffer.
// Ports: CLK/RST/CE scan control, wr_* buffer write, scroll/offset control, rows/col_select/frame_tick/offset out.
module matrix_scroll_disp #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int BUF_COLS    = 32,
  parameter int SCROLL_DIV  = 64,
  parameter int COL_ACT_LOW = 0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CE,
  input  logic                        wr_en,
  input  logic [$clog2(BUF_COLS)-1:0] wr_addr,
  input  logic [ROWS-1:0]             wr_data,
  input  logic                        scroll_en,
  input  logic                        dir,
  input  logic                        offset_load,
  input  logic [$clog2(BUF_COLS)-1:0] offset_in,
  output logic [ROWS-1:0]             rows,
  output logic [COLS-1:0]             col_select,
  output logic                        frame_tick,
  output logic [$clog2(BUF_COLS)-1:0] offset
);

  localparam int AW = $clog2(BUF_COLS);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [AW:0]     NBUF   = (AW+1)'(BUF_COLS);
  localparam logic [AW-1:0]   LAST_A = AW'(BUF_COLS - 1);
  localparam logic [CW-1:0]   LAST_C = CW'(COLS - 1);
  localparam logic [FW-1:0]   LAST_F = FW'(SCROLL_DIV - 1);
  localparam logic [COLS-1:0] IDLE   = (COL_ACT_LOW != 0) ? '1 : '0;

  logic [ROWS-1:0] mem_q [BUF_COLS];
  logic [CW-1:0]   col_q;
  logic [AW-1:0]   off_q;
  logic [AW-1:0]   pend_q;
  logic            pend_v_q;
  logic [FW-1:0]   fcnt_q;
  logic [ROWS-1:0] rows_q;
  logic [COLS-1:0] csel_q;
  logic            tick_q;

  logic [AW:0]     sum;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   ld_val;
  logic [AW-1:0]   step_off;
  logic [COLS-1:0] onehot;
  logic            frame_end;
  logic            wr_ok;

  // Window address wraps with one subtract since COLS <= BUF_COLS.
  always_comb begin
    sum    = {1'b0, off_q} + (AW+1)'(col_q);
    rd_idx = (sum >= NBUF) ? AW'(sum - NBUF) : AW'(sum);
    if ({1'b0, offset_in} >= NBUF) ld_val = AW'({1'b0, offset_in} - NBUF);
    else                           ld_val = offset_in;
    if (dir) step_off = (off_q == '0) ? LAST_A : off_q - 1'b1;
    else     step_off = (off_q == LAST_A) ? '0 : off_q + 1'b1;
    onehot    = COLS'(1) << col_q;
    frame_end = CE && (col_q == LAST_C);
    wr_ok     = ({1'b0, wr_addr} < NBUF);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BUF_COLS; i++) mem_q[i] <= '0;
      col_q    <= '0;
      off_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      fcnt_q   <= '0;
      rows_q   <= '0;
      csel_q   <= IDLE;
      tick_q   <= 1'b0;
    end else begin
      if (wr_en && wr_ok) mem_q[wr_addr] <= wr_data;
      tick_q <= frame_end;
      if (CE) begin
        rows_q <= mem_q[rd_idx];
        csel_q <= onehot ^ IDLE;
        col_q  <= (col_q == LAST_C) ? '0 : col_q + 1'b1;
      end
      if (offset_load) begin
        pend_q   <= ld_val;
        pend_v_q <= 1'b1;
      end
      // Offset only changes here so a frame never tears.
      if (frame_end) begin
        if (offset_load) begin
          off_q    <= ld_val;
          pend_v_q <= 1'b0;
          fcnt_q   <= '0;
        end else if (pend_v_q) begin
          off_q    <= pend_q;
          pend_v_q <= 1'b0;
          fcnt_q   <= '0;
        end else if (!scroll_en) begin
          fcnt_q <= '0;
        end else if (fcnt_q == LAST_F) begin
          fcnt_q <= '0;
          off_q  <= step_off;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end
    end
  end

  assign rows       = rows_q;
  assign col_select = csel_q;
  assign frame_tick = tick_q;
  assign offset     = off_q;

endmodule

// File: tb/tb_matrix_scroll_disp.sv
// Bench for matrix_scroll_disp: vector table, directed corner sequences, random run vs model.
// Two instances: SCROLL_DIV=2 active-high columns, SCROLL_DIV=1 active-low columns.
module tb_matrix_scroll_disp;

  logic       CLK = 1'b0;
  logic       RST, CE, wr_en, scroll_en, dir, offset_load;
  logic [4:0] wr_addr, offset_in;
  logic [7:0] wr_data;
  logic [7:0] rows0, col0, rows1, col1;
  logic       tick0, tick1;
  logic [4:0] off0, off1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  matrix_scroll_disp #(.SCROLL_DIV(2), .COL_ACT_LOW(0)) dut0 (
    .CLK(CLK), .RST(RST), .CE(CE), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .scroll_en(scroll_en), .dir(dir),
    .offset_load(offset_load), .offset_in(offset_in),
    .rows(rows0), .col_select(col0), .frame_tick(tick0), .offset(off0));

  matrix_scroll_disp #(.SCROLL_DIV(1), .COL_ACT_LOW(1)) dut1 (
    .CLK(CLK), .RST(RST), .CE(CE), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .scroll_en(scroll_en), .dir(dir),
    .offset_load(offset_load), .offset_in(offset_in),
    .rows(rows1), .col_select(col1), .frame_tick(tick1), .offset(off1));

  // reference model: plain modular arithmetic over the buffer
  int mbuf [32];
  int mcol;
  int moff [2], mpend [2], mpv [2], mfrm [2];
  int erows [2], ecol [2];
  int etick;
  int div_k [2] = '{2, 1};
  int low_k [2] = '{0, 1};

  task automatic model_step();
    int last;
    if (RST) begin
      for (int i = 0; i < 32; i++) mbuf[i] = 0;
      mcol = 0;
      etick = 0;
      for (int k = 0; k < 2; k++) begin
        moff[k] = 0; mpv[k] = 0; mfrm[k] = 0; erows[k] = 0;
        ecol[k] = low_k[k] ? 'hFF : 0;
      end
    end else begin
      last = (CE && mcol == 7) ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
        if (CE) begin
          erows[k] = mbuf[(moff[k] + mcol) % 32];
          ecol[k] = ((1 << mcol) ^ (low_k[k] ? 'hFF : 0)) & 'hFF;
        end
        if (last) begin
          if (offset_load) begin
            moff[k] = offset_in % 32; mpv[k] = 0; mfrm[k] = 0;
          end else if (mpv[k]) begin
            moff[k] = mpend[k]; mpv[k] = 0; mfrm[k] = 0;
          end else if (!scroll_en) begin
            mfrm[k] = 0;
          end else begin
            mfrm[k]++;
            if (mfrm[k] == div_k[k]) begin
              mfrm[k] = 0;
              moff[k] = dir ? (moff[k] + 31) % 32 : (moff[k] + 1) % 32;
            end
          end
        end else if (offset_load) begin
          mpend[k] = offset_in % 32; mpv[k] = 1;
        end
      end
      etick = last;
      if (CE) mcol = (mcol + 1) % 8;
      if (wr_en && wr_addr < 32) mbuf[wr_addr] = wr_data;
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("m0_rows", rows0, erows[0]);
    chk("m0_col", col0, ecol[0]);
    chk("m0_tick", tick0, etick);
    chk("m0_off", off0, moff[0]);
    chk("m1_rows", rows1, erows[1]);
    chk("m1_col", col1, ecol[1]);
    chk("m1_tick", tick1, etick);
    chk("m1_off", off1, moff[1]);
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic load_off(input int v);
    CE = 0; offset_load = 1; offset_in = 5'(v);
    cyc();
    offset_load = 0; CE = 1;
    repeat (8) cyc();
  endtask

  typedef struct {
    logic       ce;
    logic [7:0] col;
    logic [7:0] rows;
    logic       tick;
  } vec_t;

  vec_t tbl [32];
  int   p, ticks;

  initial begin
    for (int i = 0; i < 32; i++) begin
      p = i / 2;
      tbl[i].ce   = (i % 2 == 0);
      tbl[i].col  = 8'(1 << (p % 8));
      tbl[i].rows = 8'(p % 8 + 1);
      tbl[i].tick = (i % 2 == 0) && (p % 8 == 7);
    end

    RST = 1; CE = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    scroll_en = 0; dir = 0; offset_load = 0; offset_in = 0;

    // reset with CE toggling
    for (int i = 0; i < 3; i++) begin
      CE = (i % 2 == 0);
      cyc();
      chk("rst_rows", rows0, 0);
      chk("rst_col", col0, 'h00);
      chk("rst_off", off0, 0);
      chk("rst_tick", tick0, 0);
      chk("rst_col_low", col1, 'hFF);
    end
    RST = 0; CE = 0;

    // static scan from the vector table
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; wr_addr = 5'(k); wr_data = 8'(k + 1);
      cyc();
    end
    wr_en = 0;
    ticks = 0;
    for (int i = 0; i < 32; i++) begin
      CE = tbl[i].ce;
      cyc();
      chk("tbl_col", col0, tbl[i].col);
      chk("tbl_rows", rows0, tbl[i].rows);
      chk("tbl_tick", tick0, tbl[i].tick);
      if (tick0) begin
        ticks++;
        chk("tick_col", col0, 'h80);
      end
    end
    chk("tick_count", ticks, 2);
    CE = 0;

    // scroll left across the top of the buffer
    for (int k = 0; k < 32; k++) begin
      wr_en = 1; wr_addr = 5'(k); wr_data = 8'(k);
      cyc();
    end
    wr_en = 0; scroll_en = 1; dir = 0;
    load_off(30);
    chk("ld_off30", off0, 30);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("wrap_rows", rows0, (30 + i) % 32);
    end
    chk("off_hold30", off0, 30);
    repeat (8) cyc();
    chk("off31", off0, 31);
    repeat (16) cyc();
    chk("off0_wrap", off0, 0);

    // scroll right past zero
    dir = 1;
    load_off(0);
    chk("ld_off0", off1, 0);
    repeat (8) cyc();
    chk("right_off31", off1, 31);
    cyc();
    chk("right_col0_rows", rows1, 31);
    repeat (7) cyc();
    chk("right_div2_off", off0, 31);

    // mid-frame load keeps the frame intact and clears the frame count
    scroll_en = 0; dir = 0;
    load_off(10);
    chk("ld_off10", off0, 10);
    scroll_en = 1;
    repeat (8) cyc();
    repeat (3) cyc();
    offset_load = 1; offset_in = 20;
    cyc();
    offset_load = 0;
    chk("mid_rows3", rows0, 13);
    chk("mid_off_old", off0, 10);
    for (int i = 4; i < 8; i++) begin
      cyc();
      chk("mid_rows", rows0, 10 + i);
    end
    chk("mid_off_new", off0, 20);
    repeat (8) cyc();
    chk("fcnt_cleared", off0, 20);
    repeat (8) cyc();
    chk("step_after", off0, 21);

    // write collision then reset mid-frame
    scroll_en = 0;
    load_off(0);
    repeat (2) cyc();
    wr_en = 1; wr_addr = 2; wr_data = 8'hAA;
    cyc();
    wr_en = 0;
    chk("coll_old", rows0, 2);
    repeat (5) cyc();
    repeat (3) cyc();
    chk("coll_new", rows0, 'hAA);
    repeat (2) cyc();
    RST = 1;
    cyc();
    RST = 0;
    chk("mrst_rows", rows0, 0);
    chk("mrst_col", col0, 'h00);
    chk("mrst_tick", tick0, 0);
    chk("mrst_off", off0, 0);
    chk("mrst_col_low", col1, 'hFF);
    cyc();
    chk("post_rst_col", col0, 'h01);
    chk("post_rst_rows", rows0, 0);

    // randomized run against the model
    for (int n = 0; n < 1500; n++) begin
      RST         = ($urandom_range(0, 199) == 0);
      CE          = ($urandom_range(0, 2) != 0);
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_addr     = 5'($urandom);
      wr_data     = 8'($urandom);
      if ($urandom_range(0, 31) == 0) scroll_en = ~scroll_en;
      if ($urandom_range(0, 63) == 0) dir = ~dir;
      offset_load = ($urandom_range(0, 39) == 0);
      offset_in   = 5'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
